// File: rtl/nps_phase_acc.sv
// Phase accumulator producing ROM addresses for a numerically controlled oscillator.
// Runs in bursts of BURST_LEN samples (0 = free-running); fo marks burst start and resync points.
module nps_phase_acc #(
  parameter int ACC_WIDTH = 24,
  parameter int ADR_WIDTH = 9,
  parameter int BURST_LEN = 512
) (
  input  logic                 clk,
  input  logic                 reset_x,
  input  logic                 start,
  input  logic                 set,
  input  logic                 vi,
  input  logic                 fi,
  input  logic [ACC_WIDTH-1:0] datai,
  output logic                 vo,
  output logic                 fo,
  output logic [ADR_WIDTH-1:0] datao
);

  // state | meaning
  // IDLE  | waiting for start; vi/fi ignored, set still loads freq
  // RUN   | one sample per vi=1 cycle until the burst count is reached
  typedef enum logic {IDLE, RUN} state_t;

  localparam int CNT_W = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (BURST_LEN > 0) ? CNT_W'(BURST_LEN - 1) : '0;

  state_t                state, state_nx;
  logic [ACC_WIDTH-1:0]  acc, acc_nx;
  logic [ACC_WIDTH-1:0]  freq, freq_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  first, first_nx;
  logic                  vo_nx, fo_nx;
  logic [ADR_WIDTH-1:0]  datao_nx;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state <= IDLE;
      acc   <= '0;
      freq  <= '0;
      cnt   <= '0;
      first <= 1'b0;
      vo    <= 1'b0;
      fo    <= 1'b0;
      datao <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      freq  <= freq_nx;
      cnt   <= cnt_nx;
      first <= first_nx;
      vo    <= vo_nx;
      fo    <= fo_nx;
      datao <= datao_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    freq_nx  = set ? datai : freq;
    cnt_nx   = cnt;
    first_nx = first;
    vo_nx    = 1'b0;
    fo_nx    = 1'b0;
    datao_nx = datao;

    // start outranks a coincident sample strobe
    if (start) begin
      state_nx = RUN;
      acc_nx   = '0;
      cnt_nx   = '0;
      first_nx = 1'b1;
    end else if (state == RUN && vi) begin
      vo_nx    = 1'b1;
      first_nx = 1'b0;
      cnt_nx   = cnt + CNT_W'(1);
      if (fi) begin
        datao_nx = '0;
        fo_nx    = 1'b1;
        acc_nx   = freq;
      end else begin
        datao_nx = acc[ACC_WIDTH-1 -: ADR_WIDTH];
        fo_nx    = first;
        acc_nx   = acc + freq;
      end
      if (BURST_LEN > 0 && cnt == LAST_CNT) state_nx = IDLE;
    end
  end

endmodule

// File: tb/tb_nps_phase_acc.sv
// Bench for nps_phase_acc: directed scenarios plus a randomized run, checked against
// an arithmetic phase/burst model on a default instance and a BURST_LEN=4 instance.
module tb_nps_phase_acc;

  logic        clk, reset_x, start, set, vi, fi;
  logic [23:0] datai;
  logic        vo0, fo0, vo1, fo1;
  logic [8:0]  datao0, datao1;

  int ntot = 0, npass = 0, nfail = 0;

  typedef struct {
    bit     run;
    bit     first;
    bit     vo;
    bit     fo;
    int     n;
    int     dat;
    longint ph;
    longint fr;
  } mdl_t;

  mdl_t m0, m1;

  nps_phase_acc u_dut (
    .clk(clk), .reset_x(reset_x), .start(start), .set(set), .vi(vi), .fi(fi),
    .datai(datai), .vo(vo0), .fo(fo0), .datao(datao0)
  );

  nps_phase_acc #(.BURST_LEN(4)) u_b4 (
    .clk(clk), .reset_x(reset_x), .start(start), .set(set), .vi(vi), .fi(fi),
    .datai(datai), .vo(vo1), .fo(fo1), .datao(datao1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{run: 0, first: 0, vo: 0, fo: 0, n: 0, dat: 0, ph: 0, fr: 0};
    return r;
  endfunction

  // one clock edge of the reference: phase is an integer modulo 2^24, address = phase / 2^15
  function automatic mdl_t step(mdl_t m, int blen, bit st, bit se, bit v, bit f, longint d);
    mdl_t r = m;
    r.vo = 0;
    r.fo = 0;
    if (se) r.fr = d;
    if (st) begin
      r.run = 1; r.ph = 0; r.n = 0; r.first = 1;
    end else if (m.run && v) begin
      r.vo = 1;
      r.n = m.n + 1;
      r.first = 0;
      if (f) begin
        r.dat = 0; r.fo = 1; r.ph = m.fr;
      end else begin
        r.dat = int'(m.ph / 32768);
        r.fo = m.first;
        r.ph = (m.ph + m.fr) % 64'd16777216;
      end
      if (blen > 0 && r.n == blen) r.run = 0;
    end
    return r;
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("vo", longint'(vo0), longint'(m0.vo));
    chk("fo", longint'(fo0), longint'(m0.fo));
    chk("datao", longint'(datao0), longint'(m0.dat));
    chk("b4_vo", longint'(vo1), longint'(m1.vo));
    chk("b4_fo", longint'(fo1), longint'(m1.fo));
    chk("b4_datao", longint'(datao1), longint'(m1.dat));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_x) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end else begin
      m0 = step(m0, 512, start, set, vi, fi, longint'(datai));
      m1 = step(m1, 4, start, set, vi, fi, longint'(datai));
    end
    #1;
    start = 0; set = 0; fi = 0;
    check_all();
  endtask

  initial begin
    reset_x = 0; start = 0; set = 0; vi = 0; fi = 0; datai = '0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_x = 1;

    // idle: vi/fi ignored, deassertion alone does not start
    vi = 1; fi = 1;
    repeat (3) cyc();
    chk("idle_vo", longint'(vo0), 0);
    vi = 0;

    // V1: step 2 addresses; start with vi high produces no sample
    datai = 24'h010000; set = 1; cyc();
    start = 1; vi = 1; cyc();
    chk("v1_vo_start", longint'(vo0), 0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("v1_dat", longint'(datao0), longint'(2 * k));
      chk("v1_fo", longint'(fo0), (k == 0) ? 1 : 0);
    end
    chk("b4_done_vo", longint'(vo1), 0);

    // V3: four-sample burst then idle
    vi = 0; datai = 24'h008000; set = 1; cyc();
    start = 1; cyc();
    vi = 1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("v3_vo", longint'(vo1), (k < 4) ? 1 : 0);
      chk("v3_dat", longint'(datao1), (k < 4) ? longint'(k) : 3);
    end

    // V4: vi toggling, datao held on gaps
    vi = 0; datai = 24'h010000; set = 1; start = 1; cyc();
    for (int k = 0; k < 6; k++) begin
      vi = (k % 2 == 0);
      cyc();
      chk("v4_vo", longint'(vo0), (k % 2 == 0) ? 1 : 0);
      chk("v4_dat", longint'(datao0), longint'(2 * (k / 2)));
    end

    // V5: resync then frequency change mid-run
    vi = 1; cyc();
    chk("v5_pre", longint'(datao0), 6);
    fi = 1; cyc();
    chk("v5_rs_dat", longint'(datao0), 0);
    chk("v5_rs_fo", longint'(fo0), 1);
    cyc();
    chk("v5_post", longint'(datao0), 2);
    chk("v5_post_fo", longint'(fo0), 0);
    datai = 24'h020000; set = 1; cyc();
    chk("v5_old_freq", longint'(datao0), 4);
    cyc();
    chk("v5_old_step", longint'(datao0), 6);
    cyc();
    chk("v5_new_step", longint'(datao0), 10);

    // V6: asynchronous reset mid-burst
    #3 reset_x = 0;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    chk("rst_async_vo", longint'(vo0), 0);
    chk("rst_async_dat", longint'(datao0), 0);
    check_all();
    cyc();
    #2 reset_x = 1;
    repeat (3) cyc();
    chk("rst_no_restart", longint'(vo0), 0);

    // start+set together, V2 wrap-around
    vi = 0; datai = 24'h800000; set = 1; start = 1; cyc();
    vi = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("v2_dat", longint'(datao0), (k % 2 == 1) ? 256 : 0);
    end

    // randomized traffic, long enough to finish a default-length burst
    vi = 0; datai = 24'($urandom); set = 1; start = 1; cyc();
    for (int i = 0; i < 1600; i++) begin
      vi    = ($urandom % 10) < 7;
      fi    = ($urandom % 20) == 0;
      set   = ($urandom % 30) == 0;
      datai = 24'($urandom);
      start = (i > 900) && (($urandom % 400) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
